csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the pentaRV core; successor to the single-cycle CSR register file.
- Adds set/clear CSR ops, mstatus MIE/MPIE stacking, prioritised multi-source interrupts gated by mie/mstatus, vectored mtvec, illegal-CSR detection and optional 64-bit counters.
- Sits beside the execute stage: decodes CSR instructions, redirects fetch on trap or mret.

Parameters:
- XLEN, 32, data width (only 32 supported).
- NUM_LOCAL, 4, local interrupt lines (1..16), mapped to mip/mie bits 16..16+NUM_LOCAL-1.
- MTVEC_RESET, 32'h0000_2000, mtvec reset value (MODE bits included).
- HART_ID, 0, value of mhartid.
- VENDOR_ID, 0, value of mvendorid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- csr_wr  in  1  CSR write request.
- csr_rd  in  1  CSR read request.
- csr_op  in  2  00 write, 01 set, 10 clear, 11 reserved (treated as write).
- csr_addr  in  12  CSR address.
- wdata  in  XLEN  write operand / mask.
- pc  in  XLEN  PC of the instruction in execute.
- trap_val  in  XLEN  mtval value for exceptions.
- exception  in  1  synchronous exception this cycle.
- exc_cause  in  5  exception code.
- is_mret  in  1  mret in execute.
- irq_ok  in  1  pipeline can accept an interrupt this cycle.
- irq_sw, irq_timer, irq_ext  in  1 each  level interrupt sources (MSIP, MTIP, MEIP).
- irq_local  in  NUM_LOCAL  level local interrupts.
- instret  in  1  instruction retired this cycle.
- rdata  out  XLEN  read data (combinational).
- illegal_csr  out  1  illegal access (combinational).
- trap_taken  out  1  redirect request (combinational).
- next_pc  out  XLEN  redirect target, valid while trap_taken.
- irq_pending  out  1  |(mie & mip), regardless of mstatus.MIE.

Behaviour:
- Reset: mstatus.MIE=0, MPIE=0, MPP hardwired 2'b11; mie=0; mepc=0; mcause=0; mtval=0; mscratch=0; mtvec=MTVEC_RESET; counters=0. Outputs are combinational, so with all inputs low: rdata=0, illegal_csr=0, trap_taken=0, next_pc=0.
- Implemented CSRs:
  - F11 mvendorid, F12 marchid=0, F13 mimpid=0, F14 mhartid: read-only.
  - 300 mstatus, 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 343 mtval: read/write.
  - 344 mip: read-only; level view of the sources; writes ignored without illegal.
- Read: rdata=CSR value when csr_rd and address legal, else 0.
- Write: new = wdata (write), old|wdata (set), old&~wdata (clear). Committed at posedge.
  - Write masks: mstatus bits 3 and 7 only; mie bits 3, 7, 11 and implemented local bits; mepc[1:0] forced 0; mtvec MODE 2/3 stored as 0.
- illegal_csr=1 when (csr_rd|csr_wr) with unimplemented address, or csr_wr to F11–F14. No state change on illegal access.
- Priority each cycle: exception > interrupt > mret > CSR write. A CSR write in the same cycle as a trap or mret is dropped.
- Interrupt condition: mstatus.MIE & irq_ok & |(mie&mip).
  - Selection order: MEI(11) > MSI(3) > MTI(7) > local bit 16 > 17 > ...
- Exception: trap_taken=1, next_pc=mtvec base.
  - Posedge: mepc=pc, mcause={0,exc_cause}, mtval=trap_val, MPIE=MIE, MIE=0.
- Interrupt: trap_taken=1. next_pc = base + 4*code if MODE=1, else base.
  - Posedge: mepc=pc, mcause={1,code}, mtval=0, MPIE=MIE, MIE=0.
- mret: trap_taken=1, next_pc=mepc.
  - Posedge: MIE=MPIE, MPIE=1.
- Trap entry masks interrupts from the next cycle on; no re-entry while MIE=0.
- rst wins over every event in the same cycle.

Optional Feature:
- Macro CSR_COUNTERS_EN.
- Defined: 64-bit mcycle (B00 low / B80 high) increments every cycle; minstret (B02/B82) increments when instret=1. Both are writable per 32-bit half; a write to a half overrides that cycle's increment.
- Undefined: these addresses are unimplemented and raise illegal_csr.

Test Plan:
- Reset, read 305 -> rdata=32'h0000_2000. Read 344 with all irq low -> 0. Read 7C0 -> illegal_csr=1, rdata=0.
- Write 300 = FFFF_FFFF, then read -> 0000_1888. Clear 300 with 8, then read -> 0000_1880.
- exception=1, exc_cause=2, pc=100, trap_val=DEAD_BEEF -> trap_taken=1, next_pc=2000. Next cycle: mepc=100, mcause=2, mtval=DEAD_BEEF, MIE=0.
- mtvec=2001, mie=880, MIE=1, irq_timer=1 and irq_ext=1 together -> next_pc=202C, mcause=8000_000B. Next cycle irq_pending=1 but trap_taken=0.
- After trap, is_mret=1 -> next_pc=mepc. Next cycle MIE=1, MPIE=1, and the pending timer interrupt is taken with next_pc=201C.
- CSR_COUNTERS_EN: write B00=FFFF_FFFF, then 2 cycles later B80 reads 1. Same-cycle exception and csr_wr to 340 -> mscratch unchanged.

Source files
------------

// File: rtl/csr_trap_unit.sv
// csr_trap_unit -- machine-mode CSR file and trap controller for pentaRV.
//
// Decodes CSR accesses from execute (write/set/clear), keeps mstatus MIE/MPIE,
// mie, mtvec, mscratch, mepc, mcause and mtval, arbitrates exceptions,
// interrupts and mret, and redirects fetch via trap_taken/next_pc.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   csr_wr, csr_rd, csr_op   CSR access request and op (write/set/clear)
//   csr_addr, wdata          CSR address, write operand / mask
//   pc, trap_val             PC in execute, mtval source for exceptions
//   exception, exc_cause     synchronous exception and its code
//   is_mret, irq_ok          mret in execute, pipeline can take an interrupt
//   irq_sw/timer/ext/local   level interrupt sources
//   instret                  instruction retired this cycle
//   rdata, illegal_csr       read data, illegal access flag (combinational)
//   trap_taken, next_pc      fetch redirect and target (combinational)
//   irq_pending              |(mie & mip), ignoring mstatus.MIE
//
// Optional feature: define CSR_COUNTERS_EN to add 64-bit mcycle/minstret.
module csr_trap_unit #(
  parameter int          XLEN        = 32,
  parameter int          NUM_LOCAL   = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_2000,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] VENDOR_ID   = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_wr,
  input  logic                 csr_rd,
  input  logic [1:0]           csr_op,
  input  logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      trap_val,
  input  logic                 exception,
  input  logic [4:0]           exc_cause,
  input  logic                 is_mret,
  input  logic                 irq_ok,
  input  logic                 irq_sw,
  input  logic                 irq_timer,
  input  logic                 irq_ext,
  input  logic [NUM_LOCAL-1:0] irq_local,
  input  logic                 instret,
  output logic [XLEN-1:0]      rdata,
  output logic                 illegal_csr,
  output logic                 trap_taken,
  output logic [XLEN-1:0]      next_pc,
  output logic                 irq_pending
);

  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`endif

  // Local lines occupy bits 16.. of mip/mie; unused slots read as zero.
  logic [15:0] local_mip, local_mask;
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_local
      if (gi < NUM_LOCAL) begin : g_on
        assign local_mip[gi]  = irq_local[gi];
        assign local_mask[gi] = 1'b1;
      end else begin : g_off
        assign local_mip[gi]  = 1'b0;
        assign local_mask[gi] = 1'b0;
      end
    end
  endgenerate

  logic [31:0] mip_w, mie_mask, pend_w, mstatus_w, mtvec_base;
  assign mip_w      = {local_mip, 4'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  assign mie_mask   = {local_mask, 16'h0888};
  assign pend_w     = mie_q & mip_w;
  // MPP is hardwired to machine mode (bits 12:11).
  assign mstatus_w  = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
  assign mtvec_base = {mtvec_q[31:2], 2'b00};
  assign irq_pending = |pend_w;

  // Interrupt code: MEI > MSI > MTI > lowest-numbered local line.
  // Later assignments win, so the loop runs highest-to-lowest first.
  logic [4:0] irq_code;
  always_comb begin
    irq_code = 5'd0;
    for (int i = 31; i >= 16; i--) begin
      if (pend_w[i]) irq_code = i[4:0];
    end
    if (pend_w[7])  irq_code = 5'd7;
    if (pend_w[3])  irq_code = 5'd3;
    if (pend_w[11]) irq_code = 5'd11;
  end

  logic irq_take;
  assign irq_take = mst_mie_q & irq_ok & irq_pending;

  // Address decode and current value of the addressed CSR.
  logic [31:0] csr_val;
  logic        addr_legal, addr_ro;
  always_comb begin
    csr_val    = 32'h0;
    addr_legal = 1'b1;
    addr_ro    = 1'b0;
    case (csr_addr)
      12'hF11: begin csr_val = VENDOR_ID; addr_ro = 1'b1; end
      12'hF12: addr_ro = 1'b1;
      12'hF13: addr_ro = 1'b1;
      12'hF14: begin csr_val = HART_ID; addr_ro = 1'b1; end
      12'h300: csr_val = mstatus_w;
      12'h304: csr_val = mie_q;
      12'h305: csr_val = mtvec_q;
      12'h340: csr_val = mscratch_q;
      12'h341: csr_val = mepc_q;
      12'h342: csr_val = mcause_q;
      12'h343: csr_val = mtval_q;
      12'h344: csr_val = mip_w;  // writes are legal but have no effect
`ifdef CSR_COUNTERS_EN
      12'hB00: csr_val = mcycle_q[31:0];
      12'hB80: csr_val = mcycle_q[63:32];
      12'hB02: csr_val = minstret_q[31:0];
      12'hB82: csr_val = minstret_q[63:32];
`endif
      default: addr_legal = 1'b0;
    endcase
  end

  assign illegal_csr = (csr_rd | csr_wr) & (~addr_legal | (csr_wr & addr_ro));
  assign rdata       = (csr_rd && !illegal_csr) ? csr_val : '0;

  logic [31:0] new_val;
  always_comb begin
    case (csr_op)
      2'b01:   new_val = csr_val | wdata;
      2'b10:   new_val = csr_val & ~wdata;
      default: new_val = wdata;
    endcase
  end

  assign trap_taken = exception | irq_take | is_mret;
  always_comb begin
    next_pc = '0;
    if (exception)                  next_pc = mtvec_base;
    else if (irq_take && mtvec_q[1:0] == 2'b01)
                                    next_pc = mtvec_base + {25'b0, irq_code, 2'b00};
    else if (irq_take)              next_pc = mtvec_base;
    else if (is_mret)               next_pc = mepc_q;
  end

  // Next state: exception > interrupt > mret > CSR write.
  logic wr_en;
  assign wr_en = csr_wr & ~illegal_csr & ~trap_taken;

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instret};
`endif
    if (exception) begin
      mepc_d     = pc;
      mcause_d   = {27'b0, exc_cause};
      mtval_d    = trap_val;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (irq_take) begin
      mepc_d     = pc;
      mcause_d   = {1'b1, 26'b0, irq_code};
      mtval_d    = 32'h0;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (is_mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        12'h300: begin mst_mie_d = new_val[3]; mst_mpie_d = new_val[7]; end
        12'h304: mie_d = new_val & mie_mask;
        // Reserved MODE values 2/3 fall back to direct mode.
        12'h305: mtvec_d = new_val[1] ? {new_val[31:2], 2'b00} : new_val;
        12'h340: mscratch_d = new_val;
        12'h341: mepc_d = {new_val[31:2], 2'b00};
        12'h342: mcause_d = new_val;
        12'h343: mtval_d = new_val;
`ifdef CSR_COUNTERS_EN
        12'hB00: mcycle_d[31:0]    = new_val;
        12'hB80: mcycle_d[63:32]   = new_val;
        12'hB02: minstret_d[31:0]  = new_val;
        12'hB82: minstret_d[63:32] = new_val;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
`endif
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed testbench for csr_trap_unit: CSR access, masks, traps, mret,
// interrupt priority/vectoring and, when CSR_COUNTERS_EN is defined, counters.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_wr, csr_rd;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] wdata, pc, trap_val;
  logic        exception;
  logic [4:0]  exc_cause;
  logic        is_mret, irq_ok, irq_sw, irq_timer, irq_ext;
  logic [3:0]  irq_local;
  logic        instret;
  logic [31:0] rdata, next_pc;
  logic        illegal_csr, trap_taken, irq_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_trap_unit dut (
    .clk(clk), .rst(rst), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_op(csr_op),
    .csr_addr(csr_addr), .wdata(wdata), .pc(pc), .trap_val(trap_val),
    .exception(exception), .exc_cause(exc_cause), .is_mret(is_mret),
    .irq_ok(irq_ok), .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .irq_local(irq_local), .instret(instret), .rdata(rdata),
    .illegal_csr(illegal_csr), .trap_taken(trap_taken), .next_pc(next_pc),
    .irq_pending(irq_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a read and let combinational outputs settle (no clock edge).
  task automatic rd(input logic [11:0] a);
    csr_rd = 1'b1; csr_addr = a;
    #1;
  endtask

  task automatic rd_done();
    csr_rd = 1'b0; csr_addr = 12'h0;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_wr = 1'b1; csr_op = op; csr_addr = a; wdata = d;
    tick();
    csr_wr = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; wdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; csr_wr = 0; csr_rd = 0; csr_op = 0; csr_addr = 0; wdata = 0;
    pc = 0; trap_val = 0; exception = 0; exc_cause = 0; is_mret = 0; irq_ok = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0; irq_local = 0; instret = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_illegal", {31'b0, illegal_csr}, 32'h0);
    check("reset_trap", {31'b0, trap_taken}, 32'h0);
    check("reset_next_pc", next_pc, 32'h0);
    check("reset_irq_pending", {31'b0, irq_pending}, 32'h0);

    rd(12'h305); check("mtvec_reset", rdata, 32'h0000_2000); rd_done();
    rd(12'h344); check("mip_idle", rdata, 32'h0); rd_done();
    rd(12'h7C0);
    check("illegal_7c0", {31'b0, illegal_csr}, 32'h1);
    check("illegal_7c0_rdata", rdata, 32'h0);
    rd_done();

    // mstatus write mask and clear op
    wr(2'b00, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300); check("mstatus_wr_mask", rdata, 32'h0000_1888); rd_done();
    wr(2'b10, 12'h300, 32'h8);
    rd(12'h300); check("mstatus_clear", rdata, 32'h0000_1880); rd_done();

    // misc masks / legality
    wr(2'b00, 12'h305, 32'h0000_3002);
    rd(12'h305); check("mtvec_mode2", rdata, 32'h0000_3000); rd_done();
    wr(2'b00, 12'h341, 32'h0000_0103);
    rd(12'h341); check("mepc_align", rdata, 32'h0000_0100); rd_done();
    csr_wr = 1'b1; csr_addr = 12'hF11; #1;
    check("wr_mvendorid_illegal", {31'b0, illegal_csr}, 32'h1);
    csr_addr = 12'h344; #1;
    check("wr_mip_legal", {31'b0, illegal_csr}, 32'h0);
    tick(); csr_wr = 1'b0; csr_addr = 0;
    wr(2'b00, 12'h305, 32'h0000_2000);
    wr(2'b00, 12'h340, 32'h0000_1234);

    // exception, with a same-cycle mscratch write that must be dropped
    exception = 1; exc_cause = 5'd2; pc = 32'h100; trap_val = 32'hDEAD_BEEF;
    csr_wr = 1'b1; csr_addr = 12'h340; wdata = 32'h5555_5555;
    #1;
    check("exc_trap_taken", {31'b0, trap_taken}, 32'h1);
    check("exc_next_pc", next_pc, 32'h0000_2000);
    tick();
    exception = 0; exc_cause = 0; trap_val = 0; csr_wr = 0; csr_addr = 0; wdata = 0;
    rd(12'h341); check("exc_mepc", rdata, 32'h100); rd_done();
    rd(12'h342); check("exc_mcause", rdata, 32'h2); rd_done();
    rd(12'h343); check("exc_mtval", rdata, 32'hDEAD_BEEF); rd_done();
    rd(12'h300); check("exc_mstatus", rdata, 32'h0000_1800); rd_done();
    rd(12'h340); check("exc_mscratch_kept", rdata, 32'h0000_1234); rd_done();

    // interrupt: vectored, ext and timer together, ext wins
    wr(2'b00, 12'h305, 32'h0000_2001);
    wr(2'b00, 12'h304, 32'h0000_0880);
    wr(2'b00, 12'h300, 32'h0000_0008);
    irq_timer = 1; irq_ext = 1; pc = 32'h200; #1;
    check("irq_gated_by_ok", {31'b0, trap_taken}, 32'h0);
    check("irq_pending_on", {31'b0, irq_pending}, 32'h1);
    irq_ok = 1; #1;
    check("irq_trap_taken", {31'b0, trap_taken}, 32'h1);
    check("irq_next_pc_ext", next_pc, 32'h0000_202C);
    tick();
    check("irq_no_reentry", {31'b0, trap_taken}, 32'h0);
    check("irq_still_pending", {31'b0, irq_pending}, 32'h1);
    rd(12'h342); check("irq_mcause", rdata, 32'h8000_000B); rd_done();
    rd(12'h341); check("irq_mepc", rdata, 32'h200); rd_done();
    rd(12'h343); check("irq_mtval", rdata, 32'h0); rd_done();
    rd(12'h300); check("irq_mstatus", rdata, 32'h0000_1880); rd_done();

    // mret, then the still-pending timer interrupt is taken
    irq_ext = 0; is_mret = 1; pc = 32'h300; #1;
    check("mret_trap_taken", {31'b0, trap_taken}, 32'h1);
    check("mret_next_pc", next_pc, 32'h200);
    tick();
    is_mret = 0; pc = 32'h400; #1;
    rd(12'h300); check("mret_mstatus", rdata, 32'h0000_1888); rd_done();
    check("timer_trap_taken", {31'b0, trap_taken}, 32'h1);
    check("timer_next_pc", next_pc, 32'h0000_201C);
    tick();
    rd(12'h342); check("timer_mcause", rdata, 32'h8000_0007); rd_done();
    irq_timer = 0; irq_ok = 0;

`ifdef CSR_COUNTERS_EN
    wr(2'b00, 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd(12'hB80); check("mcycle_carry", rdata, 32'h1); rd_done();
    wr(2'b00, 12'hB02, 32'h5);
    rd(12'hB02); check("minstret_wr", rdata, 32'h5); rd_done();
    instret = 1; tick(); instret = 0;
    rd(12'hB02); check("minstret_inc", rdata, 32'h6); rd_done();
`else
    rd(12'hB00); check("mcycle_absent", {31'b0, illegal_csr}, 32'h1); rd_done();
    rd(12'hB82); check("minstreth_absent", {31'b0, illegal_csr}, 32'h1); rd_done();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
